mul2_arbiter: RTL and testbench
===============================

Name: mul2_arbiter

Overview:
- Round-robin scheduler that shares one pipelined mul2 multiplier between N_REQ requesters.
- Accepts operand pairs via req/gnt and drives the multiplier's operand ports.
- Tracks the requester ID of every in-flight operation in a tag pipeline aligned to the multiplier latency, and returns each product with its ID.
- Provides a drain control so software or sequencing logic can quiesce the multiplier.

Parameters:
- N_REQ, 4, number of requesters (power of two, 2..8).
- DATA_W, 32, operand and product width; matches mul2 a/b/ab.
- MUL_LAT, 1, clock cycles from mul_a/mul_b sampled to mul_ab valid (≥1).
- ID_W, $clog2(N_REQ), requester ID width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low: clears all state when 0.
- req  in  N_REQ  per-requester request; held until granted.
- a_in  in  N_REQ*DATA_W  flattened operand A; slice i belongs to requester i.
- b_in  in  N_REQ*DATA_W  flattened operand B.
- gnt  out  N_REQ  one-hot accept, combinational, same cycle as req.
- drain  in  1  level; stop granting and empty the pipeline.
- drained  out  1  high in DRAIN state with zero in-flight ops.
- mul_a  out  DATA_W  to mul2 .a, registered.
- mul_b  out  DATA_W  to mul2 .b, registered.
- mul_vld  out  1  operands on mul_a/mul_b are a real issue.
- mul_ab  in  DATA_W  from mul2 .ab.
- rsp_valid  out  1  result pulse, registered.
- rsp_id  out  ID_W  requester that owns rsp_data.
- rsp_data  out  DATA_W  product, registered copy of mul_ab.
- busy  out  1  any op in flight or rsp_valid high.

Behaviour:
- Reset values (rst=0, asynchronous):
  - gnt=0, mul_a=0, mul_b=0, mul_vld=0, rsp_valid=0, rsp_id=0, rsp_data=0.
  - drained=0, busy=0, tag pipe cleared, rr pointer=0, state=IDLE.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN when any req=1 and drain=0.
  - RUN→IDLE when no req and no op in flight.
  - IDLE/RUN→DRAIN when drain=1.
  - DRAIN→IDLE when drain=0. drain falling while ops are still in flight also returns to IDLE; those ops complete normally.
- Granting:
  - gnt is nonzero only when drain=0 and state≠DRAIN. IDLE grants combinationally, so the first request is granted in its first cycle.
  - At most one gnt bit per cycle. The winner is the first set req bit at or after rr pointer, modulo N_REQ.
  - On grant to i, rr pointer ← (i+1) mod N_REQ at the clock edge. With no grant the pointer holds.
- Issue: on a grant in cycle t, at edge t+1:
  - mul_a←a_in[i], mul_b←b_in[i], mul_vld←1.
  - Tag stage 0 ← {1,i}.
  - With no grant, mul_vld←0 and mul_a/mul_b hold their value (no toggling).
- Tag pipe: MUL_LAT stages of {vld,id}, shifted every cycle with no stall. The multiplier always accepts.
- Response: when the last tag stage is valid, at the next edge rsp_valid←1, rsp_id←id, rsp_data←mul_ab. Otherwise rsp_valid←0 and rsp_data holds.
- Latency: req&gnt in cycle t → rsp_valid in cycle t+2+MUL_LAT.
- Throughput: one op per cycle sustained. Back-to-back grants to the same requester are allowed only when no other req is pending.
- Arithmetic: the block does no math. rsp_data is bit-exact mul_ab (low DATA_W bits of the product, wrap-around is the multiplier's).
- drained = (state==DRAIN) & no tag valid & ~rsp_valid.
- busy = any tag valid | rsp_valid.
- Simultaneous events:
  - drain and req in the same cycle: no grant.
  - req deasserted in the same cycle it would win: no grant, pointer unchanged.
- Reset mid-operation: all in-flight tags are dropped and no rsp_valid is emitted for them. mul_ab content after reset is ignored.

Decomposition:
- Package mul2_pkg:
  - DATA_W default and MUL_LAT default.
  - FSM state enum {IDLE, RUN, DRAIN}.
  - tag struct {vld, id}.
- Sub-module rr_arbiter (N_REQ): req, rr pointer in → one-hot gnt, winner index out. Combinational, reusable.
- Tag shift register stays inline.
- mul2 is instantiated by the parent, not inside this block.

Test Plan:
- Single request: req=0001, a=0x00000003, b=0x00000005, MUL_LAT=1 → gnt=0001 same cycle; rsp_valid 3 cycles later with rsp_id=0, rsp_data=0x0000000F.
- All requesters: req=1111 held for 8 cycles, operands a=i+1, b=0x10 → gnt order 0,1,2,3,0,1,2,3. Responses in the same order, data 0x10, 0x20, 0x30, 0x40.
- Drain: drain=1 with 2 ops in flight and req=1111 → gnt=0 from that cycle; both responses still return; drained=1 the cycle after the last rsp_valid. drain=0 → granting resumes at the saved rr pointer.
- Reset mid-flight: async rst=0 with 2 ops in flight, no clock edge → all outputs 0 immediately. After release no rsp_valid ever appears for the dropped ops.
- Pointer fairness: req=0100 granted, then req=0011 → gnt=0001 (wrap from pointer 3 to requester 0), then gnt=0010.
- Latency parameter: rebuild with MUL_LAT=3 and a mul2 model of depth 3 → response 5 cycles after grant, with the correct id and data for 4 back-to-back ops.

Source files
------------

// File: rtl/mul2_pkg.sv
// mul2_pkg: shared defaults, FSM states and tag format for the mul2 arbiter.
// Revision 1.0
`default_nettype none

package mul2_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int MUL_LAT_DEF = 1;
  // Wide enough for the largest supported N_REQ (8)
  localparam int TAG_ID_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
// Revision 1.0
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  logic [ID_W-1:0] cand;

  // N_REQ is a power of two, so the ID_W-bit add wraps modulo N_REQ for free
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ptr + ID_W'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    gnt[idx] = any;
  end

endmodule

`default_nettype wire

// File: rtl/mul2_arbiter.sv
// mul2_arbiter: round-robin sharing of one pipelined mul2 among N_REQ requesters.
// Revision 1.0
`default_nettype none

module mul2_arbiter
  import mul2_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] a_in,
  input  logic [N_REQ*DATA_W-1:0] b_in,
  output logic [N_REQ-1:0]        gnt,
  input  logic                    drain,
  output logic                    drained,
  output logic [DATA_W-1:0]       mul_a,
  output logic [DATA_W-1:0]       mul_b,
  output logic                    mul_vld,
  input  logic [DATA_W-1:0]       mul_ab,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    busy
);

  state_t             state, state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    win_idx;
  logic [N_REQ-1:0]   arb_gnt;
  logic               win_any;
  logic               grant_en;
  logic               granted;
  logic               inflight;
  logic               unused_tag_id;
  logic [DATA_W-1:0]  a_arr [N_REQ];
  logic [DATA_W-1:0]  b_arr [N_REQ];

  // Stage 0 travels beside mul_a/mul_b; stage MUL_LAT lines up with a valid mul_ab
  tag_t [MUL_LAT:0]   tag_pipe;

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign a_arr[g] = a_in[g*DATA_W +: DATA_W];
    assign b_arr[g] = b_in[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req (req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  assign grant_en = rst & ~drain & (state != DRAIN);
  assign granted  = grant_en & win_any;
  assign gnt      = granted ? arb_gnt : '0;

  always_comb begin
    inflight = 1'b0;
    for (int s = 0; s <= MUL_LAT; s++) begin
      inflight = inflight | tag_pipe[s].vld;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (drain)     state_nxt = DRAIN;
        else if (|req) state_nxt = RUN;
      end
      RUN: begin
        if (drain)                  state_nxt = DRAIN;
        else if (!(|req) && !inflight) state_nxt = IDLE;
      end
      DRAIN: begin
        if (!drain) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      tag_pipe  <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      state           <= state_nxt;
      tag_pipe[0].vld <= granted;
      tag_pipe[0].id  <= TAG_ID_W'(win_idx);
      for (int s = 1; s <= MUL_LAT; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
      // Operands hold when idle so the multiplier inputs do not toggle
      if (granted) begin
        rr_ptr <= win_idx + ID_W'(1);
        mul_a  <= a_arr[win_idx];
        mul_b  <= b_arr[win_idx];
      end
      rsp_valid <= tag_pipe[MUL_LAT].vld;
      if (tag_pipe[MUL_LAT].vld) begin
        rsp_id   <= tag_pipe[MUL_LAT].id[ID_W-1:0];
        rsp_data <= mul_ab;
      end
    end
  end

  assign unused_tag_id = ^tag_pipe[MUL_LAT].id;
  assign mul_vld       = tag_pipe[0].vld;
  assign drained       = (state == DRAIN) & ~inflight & ~rsp_valid;
  assign busy          = inflight | rsp_valid;

endmodule

`default_nettype wire

// File: tb/tb_mul2_arbiter.sv
// tb_mul2_arbiter: scoreboard bench for mul2_arbiter at MUL_LAT=1 and MUL_LAT=3.
// Revision 1.0
`default_nettype none

module tb_mul2_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk   = 1'b0;
  logic            rst   = 1'b0;
  logic [N-1:0]    req   = '0;
  logic [N-1:0]    req3  = '0;
  logic            drain = 1'b0;
  logic [N*DW-1:0] a_in  = '0;
  logic [N*DW-1:0] b_in  = '0;

  logic [N-1:0]  gnt, gnt3;
  logic          drained, drained3, mul_vld, mul_vld3;
  logic          rsp_valid, rsp_valid3, busy, busy3;
  logic [DW-1:0] mul_a, mul_b, mul_a3, mul_b3, rsp_data, rsp_data3, mul_ab3;
  logic [DW-1:0] mul_ab = '0;
  logic [1:0]    rsp_id, rsp_id3;
  logic [DW-1:0] p3 [3];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3, ex;

  mul2_arbiter #(.N_REQ(N), .DATA_W(DW), .MUL_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .drain(drain), .drained(drained), .mul_a(mul_a), .mul_b(mul_b),
    .mul_vld(mul_vld), .mul_ab(mul_ab), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  mul2_arbiter #(.N_REQ(N), .DATA_W(DW), .MUL_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req(req3), .a_in(a_in), .b_in(b_in), .gnt(gnt3),
    .drain(1'b0), .drained(drained3), .mul_a(mul_a3), .mul_b(mul_b3),
    .mul_vld(mul_vld3), .mul_ab(mul_ab3), .rsp_valid(rsp_valid3),
    .rsp_id(rsp_id3), .rsp_data(rsp_data3), .busy(busy3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mul2 models of depth 1 and 3
  always @(posedge clk) mul_ab <= mul_a * mul_b;
  always @(posedge clk) begin
    p3[0] <= mul_a3 * mul_b3;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mul_ab3 = p3[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] oh2i(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Expected entries come from the caller's hand values, never from the DUT
  task automatic drive(input logic [3:0] r, input logic [3:0] eg, input logic [31:0] ed,
                       input bit push, input string name);
    @(negedge clk);
    req = r;
    #1;
    chk(name, gnt, eg);
    if (push && eg != 0) begin
      ex.id = oh2i(eg); ex.data = ed; ex.due = cyc + 3;
      q1.push_back(ex);
    end
  endtask

  task automatic drive3(input logic [3:0] r, input logic [3:0] eg, input logic [31:0] ed,
                        input string name);
    @(negedge clk);
    req3 = r;
    #1;
    chk(name, gnt3, eg);
    ex.id = oh2i(eg); ex.data = ed; ex.due = cyc + 5;
    q3.push_back(ex);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req = '0; req3 = '0; drain = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (rst && rsp_valid) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_rsp1 actual id=%0d data=%0h required=no response", rsp_id, rsp_data);
      end else begin
        e1 = q1.pop_front();
        chk("rsp1_id", rsp_id, e1.id);
        chk("rsp1_data", rsp_data, e1.data);
        chk("rsp1_cycle", cyc, e1.due);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst && rsp_valid3) begin
      if (q3.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_rsp3 actual id=%0d data=%0h required=no response", rsp_id3, rsp_data3);
      end else begin
        e3 = q3.pop_front();
        chk("rsp3_id", rsp_id3, e3.id);
        chk("rsp3_data", rsp_data3, e3.data);
        chk("rsp3_cycle", cyc, e3.due);
      end
    end
  end

  logic [3:0]  rr_exp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                             4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [31:0] rr_dat [8] = '{32'h10, 32'h20, 32'h30, 32'h40,
                             32'h10, 32'h20, 32'h30, 32'h40};
  logic [3:0]  drained_exp = 4'b1000;

  initial begin
    // Reset state, with requests pending to show gnt is gated
    rst = 1'b0;
    req = 4'b1111;
    @(negedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_vld", mul_vld, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_drained", drained, 0);
    chk("rst_busy", busy, 0);
    req = '0;
    @(negedge clk);
    rst = 1'b1;

    // Single request: 3 * 5
    a_in[31:0] = 32'd3;
    b_in[31:0] = 32'd5;
    drive(4'b0001, 4'b0001, 32'h0000000F, 1'b1, "single_gnt");
    @(negedge clk);
    req = '0;
    #1;
    chk("single_busy", busy, 1);
    chk("single_mul_vld", mul_vld, 1);
    chk("single_mul_a", mul_a, 3);
    idle(4);

    for (int i = 0; i < N; i++) begin
      a_in[i*DW +: DW] = DW'(i + 1);
      b_in[i*DW +: DW] = 32'h10;
    end

    // All requesters held: strict rotation
    do_reset();
    for (int k = 0; k < 8; k++) drive(4'b1111, rr_exp[k], rr_dat[k], 1'b1, "rr_gnt");
    @(negedge clk);
    req = '0;
    idle(5);

    // Drain with two ops in flight
    do_reset();
    drive(4'b1111, 4'b0001, 32'h10, 1'b1, "drain_pre0");
    drive(4'b1111, 4'b0010, 32'h20, 1'b1, "drain_pre1");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drain = 1'b1;
      req   = 4'b1111;
      #1;
      chk("drain_gnt", gnt, 0);
      chk("drained", drained, drained_exp[k]);
    end
    @(negedge clk);
    drain = 1'b0;
    #1;
    chk("drain_exit_gnt", gnt, 0);
    drive(4'b1111, 4'b0100, 32'h30, 1'b1, "resume0");
    drive(4'b1111, 4'b1000, 32'h40, 1'b1, "resume1");
    @(negedge clk);
    req = '0;
    idle(5);

    // Async reset with two ops in flight: nothing may come back
    do_reset();
    drive(4'b0011, 4'b0001, 32'h10, 1'b0, "mid_gnt0");
    drive(4'b0011, 4'b0010, 32'h20, 1'b0, "mid_gnt1");
    @(negedge clk);
    req = 4'b1111;
    rst = 1'b0;
    #1;
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_mul_vld", mul_vld, 0);
    chk("mid_rst_mul_a", mul_a, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    idle(6);

    // Pointer fairness and wrap
    drive(4'b0100, 4'b0100, 32'h30, 1'b1, "fair0");
    drive(4'b0011, 4'b0001, 32'h10, 1'b1, "fair_wrap");
    drive(4'b0011, 4'b0010, 32'h20, 1'b1, "fair2");
    @(negedge clk);
    req = '0;
    idle(4);

    // MUL_LAT=3 instance: four back-to-back ops
    for (int k = 0; k < 4; k++) drive3(4'b1111, rr_exp[k], rr_dat[k], "lat3_gnt");
    @(negedge clk);
    req3 = '0;

    for (int w = 0; w < 30 && (q1.size() != 0 || q3.size() != 0); w++) @(negedge clk);
    while (q1.size() != 0) begin
      ex = q1.pop_front();
      checks++; failures++;
      $display("FAIL missing_rsp1 actual=none required id=%0d data=%0h", ex.id, ex.data);
    end
    while (q3.size() != 0) begin
      ex = q3.pop_front();
      checks++; failures++;
      $display("FAIL missing_rsp3 actual=none required id=%0d data=%0h", ex.id, ex.data);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
